sprite_blitter: RTL

Parametrised image-to-framebuffer copier for the VGA display path. On a `start` pulse it scans a rectangular image held in one of `N_IMG` on-chip ROMs and emits one pixel write per cycle (x, y, linear framebuffer address, colour, `plot` strobe) at a runtime-selectable screen origin. It serves banner/message overlays (win, lose, tie) and board sprites, and adds the following:

- ROM-latency alignment
- screen clipping
- a `busy`/`done` handshake
- a single terminated scan instead of free-running repetition

---
 rtl/sprite_blitter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one IMG_W x IMG_H image ROM to the framebuffer per start pulse, with clipping.
// Define SPRITE_BLITTER_TRANSPARENT_EN to suppress plots of TRANSPARENT_COLOUR pixels.
module sprite_blitter #(
   parameter int IMG_W = 50,
   parameter int IMG_H = 40,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int COLOUR_W = 3,
   parameter int N_IMG = 3,
   parameter int ROM_LAT = 1,
   parameter int FB_ADDR_W = 15,
   parameter int TRANSPARENT_COLOUR = 0,
   localparam int ROM_ADDR_W = $clog2(IMG_W * IMG_H),
   localparam int SEL_W = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SEL_W-1:0]          img_sel,
   input  logic [X_W-1:0]            origin_x,
   input  logic [Y_W-1:0]            origin_y,
   output logic [ROM_ADDR_W-1:0]     rom_addr,
   input  logic [N_IMG*COLOUR_W-1:0] rom_data,
   output logic [X_W-1:0]            dataX,
   output logic [Y_W-1:0]            dataY,
   output logic [FB_ADDR_W-1:0]      writeToMemAddress,
   output logic [COLOUR_W-1:0]       colour,
   output logic                      plot,
   output logic                      busy,
   output logic                      done
);
   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   state_t state, state_n;

   logic [SEL_W-1:0] sel;
   logic [X_W-1:0] ox;
   logic [Y_W-1:0] oy;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [ROM_LAT-1:0] pv;
   logic [CW-1:0] pcol [ROM_LAT];
   logic [RW-1:0] prow [ROM_LAT];
   logic out_v, last_col, last, vis;
   logic [X_W:0] x;
   logic [Y_W:0] y;
   logic [COLOUR_W-1:0] pix;

   assign last_col = col == CW'(IMG_W - 1);
   assign last = last_col && row == RW'(IMG_H - 1);
   // tokens leave the pipeline in step with the ROM data for their address
   assign x = {1'b0, ox} + (X_W + 1)'(pcol[ROM_LAT-1]);
   assign y = {1'b0, oy} + (Y_W + 1)'(prow[ROM_LAT-1]);
   assign vis = 32'(x) < SCREEN_W && 32'(y) < SCREEN_H && !(KEY_EN && pix == COLOUR_W'(TRANSPARENT_COLOUR));
   assign busy = state != IDLE;

   always_comb begin
      pix = '0;
      for (int i = 0; i < N_IMG; i++)
         if (SEL_W'(i) == sel) pix = rom_data[i*COLOUR_W +: COLOUR_W];
   end

   always_comb begin
      state_n = state;
      done = 1'b0;
      case (state)
         IDLE: state_n = start ? SCAN : IDLE;
         SCAN: state_n = last ? DRAIN : SCAN;
         DRAIN: begin
            done = !(|pv) && !out_v;
            state_n = done ? IDLE : DRAIN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel <= '0;
         ox <= '0;
         oy <= '0;
         col <= '0;
         row <= '0;
         rom_addr <= '0;
         pv <= '0;
      end else begin
         if (state == IDLE && start) begin
            sel <= img_sel;
            ox <= origin_x;
            oy <= origin_y;
            col <= '0;
            row <= '0;
            rom_addr <= '0;
         end else if (state == SCAN) begin
            col <= last_col ? '0 : col + CW'(1);
            row <= last_col ? row + RW'(1) : row;
            rom_addr <= rom_addr + ROM_ADDR_W'(1);
         end
         pv <= ROM_LAT'({pv, state == SCAN});
      end
   end

   always_ff @(posedge clk) begin
      pcol[0] <= col;
      prow[0] <= row;
      for (int i = 1; i < ROM_LAT; i++) begin
         pcol[i] <= pcol[i-1];
         prow[i] <= prow[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_v <= 1'b0;
         plot <= 1'b0;
         dataX <= '0;
         dataY <= '0;
         writeToMemAddress <= '0;
         colour <= '0;
      end else begin
         out_v <= pv[ROM_LAT-1];
         plot <= pv[ROM_LAT-1] && vis;
         if (pv[ROM_LAT-1]) begin
            dataX <= x[X_W-1:0];
            dataY <= y[Y_W-1:0];
            writeToMemAddress <= FB_ADDR_W'(32'(y) * SCREEN_W + 32'(x));
            colour <= pix;
         end
      end
   end
endmodule
